// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RISC-V decode definitions. Holds the base opcode constants,
//          the immediate-format encodings, the skid-buffer state type and the
//          buffered entry struct used by id_decode_buffer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  // Widest instruction/PC width an entry can carry; narrower builds
  // zero-extend into the entry and slice back out on the way to EX.
  localparam int RV_MAX_XLEN = 64;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  // Immediate-format select
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // Skid-buffer occupancy
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // One buffered instruction with its decode result
  typedef struct packed {
    logic [RV_MAX_XLEN-1:0] instr;
    logic [RV_MAX_XLEN-1:0] pc;
    logic [2:0]             imm_type;
    logic                   illegal;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/imm_type_decoder.sv
// ============================================================================
// Module : imm_type_decoder
// Brief  : Purely combinational opcode decoder. Maps a base opcode onto its
//          immediate-format select and flags opcodes the core does not support.
// Ports  : i_opcode   [6:0] instruction opcode field
//          o_imm_type [2:0] immediate format (IMM_I..IMM_J, IMM_NONE)
//          o_illegal        opcode not supported
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_type_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [2:0] o_imm_type,
  output logic       o_illegal
);

  always_comb begin
    // Unknown opcodes fall through to "no immediate, illegal"
    o_imm_type = IMM_NONE;
    o_illegal  = 1'b1;
    case (i_opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        o_imm_type = IMM_I;
        o_illegal  = 1'b0;
      end
      OPC_STORE: begin
        o_imm_type = IMM_S;
        o_illegal  = 1'b0;
      end
      OPC_BRANCH: begin
        o_imm_type = IMM_B;
        o_illegal  = 1'b0;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_imm_type = IMM_U;
        o_illegal  = 1'b0;
      end
      OPC_JAL: begin
        o_imm_type = IMM_J;
        o_illegal  = 1'b0;
      end
      OPC_OP: begin
        // Register-register ops carry no immediate but are legal
        o_imm_type = IMM_NONE;
        o_illegal  = 1'b0;
      end
      default: begin
        o_imm_type = IMM_NONE;
        o_illegal  = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_decode_buffer.sv
// ============================================================================
// Module : id_decode_buffer
// Brief  : Two-entry skid buffer between IF/ID and EX. Each instruction is
//          decoded (immediate format / illegal) as it is accepted and is
//          presented to EX one cycle later. All outputs come from registers.
// Config : ID_DECODE_STALL_CNT_EN - adds a saturating 32-bit stall_cnt output
//          counting cycles where the head is valid but EX is not ready.
// Ports  : clk, rst (async, active-high), flush (sync pipeline flush)
//          in_valid / in_ready / in_instr / in_pc          upstream handshake
//          out_valid / out_ready / out_instr / out_pc      downstream handshake
//          out_imm_type, out_illegal                       head decode result
//          stall_cnt                                        (optional)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module id_decode_buffer
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
`ifdef ID_DECODE_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  entry_t     r_head;      // entry visible to EX
  entry_t     r_skid;      // second entry, only meaningful in ST_TWO
  entry_t     w_new;       // decoded incoming entry
  logic       r_in_ready;
  logic [2:0] w_imm_type;
  logic       w_illegal;
  logic       w_accept;
  logic       w_pop;

  imm_type_decoder u_imm_type_decoder (
    .i_opcode   (in_instr[6:0]),
    .o_imm_type (w_imm_type),
    .o_illegal  (w_illegal)
  );

  always_comb begin
    w_new          = '0;
    w_new.instr    = RV_MAX_XLEN'(in_instr);
    w_new.pc       = RV_MAX_XLEN'(in_pc);
    w_new.imm_type = w_imm_type;
    w_new.illegal  = w_illegal;
  end

  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = r_in_ready;
  assign w_accept  = in_valid && r_in_ready;
  assign w_pop     = out_valid && out_ready;

  // --------------------------------------------------------------------------
  // Occupancy FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      // Flush wins over any same-cycle accept or pop
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
        ST_ONE: begin
          if (w_accept && !w_pop)      w_state_nxt = ST_TWO;
          else if (!w_accept && w_pop) w_state_nxt = ST_EMPTY;
        end
        ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // in_ready is registered from the next state so upstream sees no
  // combinational path from out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != ST_TWO);
    end
  end

  // --------------------------------------------------------------------------
  // Entry storage. Data is left untouched on flush; out_valid gates it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) r_head <= w_new;
        end
        ST_ONE: begin
          // Accept+pop replaces the head directly; accept alone parks in skid
          if (w_accept && w_pop) r_head <= w_new;
          else if (w_accept)     r_skid <= w_new;
        end
        ST_TWO: begin
          if (w_pop) r_head <= r_skid;
        end
        default: ;
      endcase
    end
  end

  assign out_instr    = r_head.instr[XLEN-1:0];
  assign out_pc       = r_head.pc[XLEN-1:0];
  assign out_imm_type = r_head.imm_type;
  assign out_illegal  = r_head.illegal;

  // Upper entry bits above XLEN are always zero and never leave the block
  generate
    if (XLEN < RV_MAX_XLEN) begin : g_hi_unused
      logic w_unused_hi;
      assign w_unused_hi = ^{r_head.instr[RV_MAX_XLEN-1:XLEN],
                             r_head.pc[RV_MAX_XLEN-1:XLEN]};
    end
  endgenerate

`ifdef ID_DECODE_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Stall counter: saturates, cleared only by reset (flush leaves it alone)
  // --------------------------------------------------------------------------
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_decode_buffer.sv
// ============================================================================
// Module : tb_id_decode_buffer
// Brief  : Self-checking bench for id_decode_buffer. A queue-based reference
//          model tracks buffer contents; directed scenarios are followed by a
//          randomized phase. Build with ID_DECODE_STALL_CNT_EN to also check
//          the stall counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_decode_buffer;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      out_imm_type;
  logic            out_illegal;
`ifdef ID_DECODE_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  id_decode_buffer #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm_type (out_imm_type),
    .out_illegal  (out_illegal)
`ifdef ID_DECODE_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [2:0]      imm;
    logic            ill;
  } mdl_t;

  mdl_t        mq[$];
  longint      m_stall;
  int          n_tests;
  int          n_fail;

  // Opcode table straight from the instruction-set formats
  function automatic mdl_t ref_entry(logic [XLEN-1:0] instr, logic [XLEN-1:0] pc);
    mdl_t e;
    e.instr = instr;
    e.pc    = pc;
    e.ill   = 1'b0;
    case (instr[6:0])
      7'h03, 7'h13, 7'h67, 7'h73, 7'h0F: e.imm = 3'b000;
      7'h23:                             e.imm = 3'b001;
      7'h63:                             e.imm = 3'b010;
      7'h37, 7'h17:                      e.imm = 3'b011;
      7'h6F:                             e.imm = 3'b100;
      7'h33:                             e.imm = 3'b111;
      default: begin
        e.imm = 3'b111;
        e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready",  64'(in_ready),  64'(mq.size() < 2));
    if (mq.size() > 0) begin
      chk("out_instr",    64'(out_instr),    64'(mq[0].instr));
      chk("out_pc",       64'(out_pc),       64'(mq[0].pc));
      chk("out_imm_type", 64'(out_imm_type), 64'(mq[0].imm));
      chk("out_illegal",  64'(out_illegal),  64'(mq[0].ill));
    end
`ifdef ID_DECODE_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock: predict from current inputs, advance, compare #1 after edge
  task automatic step();
    bit   acc;
    bit   pop;
    mdl_t e;
    acc = in_valid && (mq.size() < 2) && !flush;
    pop = (mq.size() > 0) && out_ready && !flush;
    if ((mq.size() > 0) && !out_ready && (m_stall < 64'hFFFF_FFFF)) m_stall++;
    e = ref_entry(in_instr, in_pc);
    @(posedge clk);
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic async_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    m_stall = 0;
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_instr",     64'(out_instr),    64'd0);
    chk("rst_pc",        64'(out_pc),       64'd0);
    chk("rst_imm",       64'(out_imm_type), 64'd0);
    chk("rst_illegal",   64'(out_illegal),  64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [6:0] opc_tab [12];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_stall = 0;
    opc_tab = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h0F, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h07};

    // ---------------- reset with in_valid high ----------------
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h00A0_0093, 32'h0000_1000);
    #3;
    chk("rst_out_valid", 64'(out_valid),    64'd0);
    chk("rst_in_ready",  64'(in_ready),     64'd1);
    chk("rst_instr",     64'(out_instr),    64'd0);
    chk("rst_pc",        64'(out_pc),       64'd0);
    chk("rst_imm",       64'(out_imm_type), 64'd0);
    chk("rst_illegal",   64'(out_illegal),  64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_valid", 64'(out_valid), 64'd0);
    drive(1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // ---------------- decode ----------------
    out_ready = 1'b1;
    drive(1'b1, 32'h00A0_0093, 32'h0000_0000); step();
    chk("dec_addi_imm", 64'(out_imm_type), 64'd0);
    chk("dec_addi_ill", 64'(out_illegal),  64'd0);
    drive(1'b1, 32'hFE20_8EE3, 32'h0000_0004); step();
    chk("dec_beq_imm",  64'(out_imm_type), 64'd2);
    drive(1'b1, 32'h0000_006F, 32'h0000_0008); step();
    chk("dec_jal_imm",  64'(out_imm_type), 64'd4);
    drive(1'b1, 32'h0000_0007, 32'h0000_000C); step();
    chk("dec_bad_imm",  64'(out_imm_type), 64'd7);
    chk("dec_bad_ill",  64'(out_illegal),  64'd1);
    drive(1'b0, '0, '0); step();

    // ---------------- backpressure A,B,C ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h0000_0A00); step();
    drive(1'b1, 32'h0000_0023, 32'h0000_0B00); step();
    chk("bp_in_ready_full", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h0000_0037, 32'h0000_0C00); step(); step();
    chk("bp_head_A", 64'(out_pc), 64'h0A00);
    out_ready = 1'b1;
    step();
    chk("bp_head_B", 64'(out_pc), 64'h0B00);
    step();
    chk("bp_head_C", 64'(out_pc), 64'h0C00);
    drive(1'b0, '0, '0); step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // ---------------- streaming accept+pop in ONE ----------------
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0000_0033 | (i << 12), 32'h100 + 32'(i * 4));
      step();
      chk("stream_pc", 64'(out_pc), 64'h100 + 64'(i * 4));
      chk("stream_rdy", 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, '0); step();

    // ---------------- flush in TWO with in_valid ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0003, 32'h0000_0D00); step();
    drive(1'b1, 32'h0000_0003, 32'h0000_0D04); step();
    drive(1'b1, 32'h0000_0003, 32'h0000_0D08);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    drive(1'b0, '0, '0); out_ready = 1'b1;
    step(); step();

`ifdef ID_DECODE_STALL_CNT_EN
    // ---------------- stall counter ----------------
    async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h0000_0E00); step();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) step();
    chk("stall_5", 64'(stall_cnt), 64'd5);
    out_ready = 1'b1; flush = 1'b1; step(); flush = 1'b0;
    step();
    chk("stall_after_flush", 64'(stall_cnt), 64'd5);
`endif

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      logic [XLEN-1:0] ins;
      ins = $urandom();
      if ($urandom_range(0, 3) != 0) ins[6:0] = opc_tab[$urandom_range(0, 11)];
      drive(($urandom_range(0, 3) != 0), ins, $urandom());
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      step();
    end
    flush = 1'b0;

    // ---------------- reset mid-operation ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h0000_0F00); step();
    drive(1'b1, 32'h0000_0013, 32'h0000_0F04); step();
    #2;
    async_reset();
    drive(1'b1, 32'h0000_006F, 32'h0000_0F10);
    step();
    chk("post_rst_pc", 64'(out_pc), 64'h0F10);
    drive(1'b0, '0, '0); out_ready = 1'b1; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the stimulus above is bounded, this guards against a hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/id_decode_buffer.md
ID_DECODE_BUFFER -- requirements
Module: id_decode_buffer

Interface
REQ-001 SHALL have parameter XLEN, default 32, instruction/PC width.
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-005 SHALL have port in_valid  input  1  upstream (IF/ID) instruction valid.
REQ-006 SHALL have port in_ready  output  1  buffer can accept this cycle.
REQ-007 SHALL have port in_instr  input  XLEN  raw instruction word.
REQ-008 SHALL have port in_pc  input  XLEN  instruction PC.
REQ-009 SHALL have port out_valid  output  1  head entry valid toward EX.
REQ-010 SHALL have port out_ready  input  1  EX consumes head this cycle.
REQ-011 SHALL have port out_instr  output  XLEN  head instruction.
REQ-012 SHALL have port out_pc  output  XLEN  head PC.
REQ-013 SHALL have port out_imm_type  output  3  immediate-format select for head.
REQ-014 SHALL have port out_illegal  output  1  head opcode unsupported.

Function
REQ-015 SHALL decode in_instr[6:0] at accept: 0000011/0010011/1100111/1110011/0001111 -> 000 (I); 0100011 -> 001 (S); 1100011 -> 010 (B); 0110111/0010111 -> 011 (U); 1101111 -> 100 (J); 0110011 -> 111 (none).
REQ-016 SHALL, for any other opcode, store imm_type 111 with illegal=1; all listed opcodes store illegal=0.
REQ-017 SHALL be a 2-entry skid buffer with FSM states EMPTY, ONE, TWO; in_ready = (state != TWO), driven from a register.
REQ-018 SHALL accept when in_valid && in_ready; pop when out_valid && out_ready; out_valid = (state != EMPTY).
REQ-019 SHALL transition: EMPTY+accept -> ONE; ONE+accept-only -> TWO; ONE+pop-only -> EMPTY; ONE+accept+pop -> ONE, new entry becoming head; TWO+pop -> ONE, skid entry moving to head; otherwise hold.
REQ-020 SHALL present a newly accepted entry on out_* the cycle after acceptance (latency 1); no combinational in->out path.
REQ-021 SHALL keep out_* stable while out_valid && !out_ready.
REQ-022 SHALL preserve strict FIFO order; no entry dropped or duplicated except by flush.
REQ-023 SHALL, on flush, go to EMPTY next cycle, discarding both entries and any same-cycle accept; flush overrides accept and pop.
REQ-024 SHALL leave out_* data unchanged (don't-care) when out_valid=0; only out_valid and in_ready are guaranteed.

Reset
REQ-025 SHALL, on rst high, asynchronously force state EMPTY, out_valid=0, in_ready=1, out_instr=0, out_pc=0, out_imm_type=000, out_illegal=0.
REQ-026 SHALL discard any in-flight entry when rst asserts mid-operation; first accept after deassertion occurs no earlier than the next rising edge.

Configuration
REQ-027 SHALL, with macro ID_DECODE_STALL_CNT_EN defined, add output stall_cnt (32 bits) counting cycles with out_valid && !out_ready, saturating at 0xFFFFFFFF, reset to 0 by rst, unaffected by flush.
REQ-028 SHALL, without ID_DECODE_STALL_CNT_EN, have no stall_cnt port or counter logic; all other behaviour identical.

Structure
REQ-029 SHALL take opcode constants, imm_type encodings (IMM_I..IMM_J, IMM_NONE=111) and an entry struct {instr, pc, imm_type, illegal} from shared package riscv_pkg.
REQ-030 SHALL place opcode->imm_type/illegal decoding in one combinational sub-module, imm_type_decoder.

Verification
REQ-031 SHALL check reset: rst=1 with in_valid=1 -> out_valid=0, in_ready=1, all out_* zero; after release, state EMPTY.
REQ-032 SHALL check decode: accept 0x00A00093 (addi) -> out_imm_type 000, illegal 0; 0xFE208EE3 (beq) -> 010; 0x0000006F (jal) -> 100; 0x00000007 -> 111, illegal 1.
REQ-033 SHALL check backpressure: out_ready=0, send instructions A, B, C -> A,B held, in_ready=0 after B, C not accepted; raise out_ready -> A, B, C emerge in order, one per cycle.
REQ-034 SHALL check simultaneous accept+pop in ONE: stream 0x100..0x10C PCs with out_ready=1 -> one output per cycle, latency 1, state stays ONE.
REQ-035 SHALL check flush in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, neither held nor incoming entry ever appears.
REQ-036 SHALL, with ID_DECODE_STALL_CNT_EN, check holding out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush leaves it 5.
